// File: rtl/display_scheduler.sv
// rtl/display_scheduler.sv - round-robin message scheduler for a 4-digit 7-segment display
module display_scheduler #(
    parameter int TICK_DIV    = 100000,
    parameter int HOLD_TICKS  = 500,
    parameter int GAP_TICKS   = 50,
    parameter int BLINK_TICKS = 100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [15:0] msg0,
    input  logic [15:0] msg1,
    input  logic [15:0] msg2,
    input  logic [2:0]  blink,
    output logic [2:0]  grant,
    output logic        done,
    output logic [15:0] graphics
);

    localparam int PW = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
    localparam int HW = (HOLD_TICKS  > 1) ? $clog2(HOLD_TICKS)  : 1;
    localparam int GW = (GAP_TICKS   > 1) ? $clog2(GAP_TICKS)   : 1;
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

    localparam logic [PW-1:0] PRE_MAX   = PW'(TICK_DIV - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_TICKS - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(GAP_TICKS - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [15:0]   BLANK     = 16'hFFFF;

    typedef enum logic [1:0] {S_IDLE, S_SHOW, S_GAP} state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic          done_q, done_d;
    logic [15:0]   gfx_q, gfx_d;
    logic [1:0]    last_q, last_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          blink_en_q, blink_en_d;
    logic          vis_q, vis_d;

    logic          tick;
    logic [2:0]    pick;
    logic [15:0]   owner_msg;
    logic [15:0]   pick_msg;

    // Round-robin choice: the requester after the last owner has first claim.
    function automatic logic [2:0] rr_pick(input logic [2:0] r, input logic [1:0] last);
        logic [2:0] p;
        p = 3'b000;
        case (last)
            2'd0: begin
                if (r[1])      p = 3'b010;
                else if (r[2]) p = 3'b100;
                else if (r[0]) p = 3'b001;
            end
            2'd1: begin
                if (r[2])      p = 3'b100;
                else if (r[0]) p = 3'b001;
                else if (r[1]) p = 3'b010;
            end
            default: begin
                if (r[0])      p = 3'b001;
                else if (r[1]) p = 3'b010;
                else if (r[2]) p = 3'b100;
            end
        endcase
        return p;
    endfunction

    function automatic logic [1:0] enc(input logic [2:0] g);
        return g[2] ? 2'd2 : (g[1] ? 2'd1 : 2'd0);
    endfunction

    // Message selection for the current owner and for a fresh grant.
    always_comb begin
        tick = (pre_q == PRE_MAX);
        pick = rr_pick(req, last_q);
        owner_msg = grant_q[2] ? msg2 : (grant_q[1] ? msg1 : msg0);
        pick_msg  = pick[2] ? msg2 : (pick[1] ? msg1 : msg0);
    end

    // Next-state logic for the scheduler and its counters.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        done_d     = 1'b0;
        gfx_d      = gfx_q;
        last_d     = last_q;
        pre_d      = tick ? '0 : pre_q + 1'b1;
        hold_d     = hold_q;
        gap_d      = gap_q;
        bcnt_d     = bcnt_q;
        blink_en_d = blink_en_q;
        vis_d      = vis_q;
        case (state_q)
            S_IDLE: begin
                pre_d   = '0;
                grant_d = 3'b000;
                gfx_d   = BLANK;
                if (req != 3'b000) begin
                    state_d    = S_SHOW;
                    grant_d    = pick;
                    last_d     = enc(pick);
                    blink_en_d = |(blink & pick);
                    vis_d      = 1'b1;
                    hold_d     = '0;
                    bcnt_d     = '0;
                    gfx_d      = pick_msg;
                end
            end
            S_SHOW: begin
                if ((req & grant_q) == 3'b000) begin
                    // Owner withdrew: cut the hold short without a done pulse.
                    state_d = S_GAP;
                    grant_d = 3'b000;
                    gfx_d   = BLANK;
                    pre_d   = '0;
                    gap_d   = '0;
                end else if (tick && hold_q == HOLD_MAX) begin
                    state_d = S_GAP;
                    grant_d = 3'b000;
                    done_d  = 1'b1;
                    gfx_d   = BLANK;
                    pre_d   = '0;
                    gap_d   = '0;
                end else begin
                    if (tick) begin
                        hold_d = hold_q + 1'b1;
                        if (blink_en_q) begin
                            if (bcnt_q == BLINK_MAX) begin
                                bcnt_d = '0;
                                vis_d  = ~vis_q;
                            end else begin
                                bcnt_d = bcnt_q + 1'b1;
                            end
                        end
                    end
                    gfx_d = vis_d ? owner_msg : BLANK;
                end
            end
            default: begin
                gfx_d   = BLANK;
                grant_d = 3'b000;
                if (tick) begin
                    if (gap_q == GAP_MAX) begin
                        state_d = S_IDLE;
                        pre_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
            end
        endcase
    end

    // State and output registers; reset wins over everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            grant_q    <= 3'b000;
            done_q     <= 1'b0;
            gfx_q      <= BLANK;
            last_q     <= 2'd2;
            pre_q      <= '0;
            hold_q     <= '0;
            gap_q      <= '0;
            bcnt_q     <= '0;
            blink_en_q <= 1'b0;
            vis_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            gfx_q      <= gfx_d;
            last_q     <= last_d;
            pre_q      <= pre_d;
            hold_q     <= hold_d;
            gap_q      <= gap_d;
            bcnt_q     <= bcnt_d;
            blink_en_q <= blink_en_d;
            vis_q      <= vis_d;
        end
    end

    assign grant    = grant_q;
    assign done     = done_q;
    assign graphics = gfx_q;

endmodule

// File: tb/tb_display_scheduler.sv
// tb/tb_display_scheduler.sv - scoreboard bench for display_scheduler
module tb_display_scheduler;

    localparam int TD = 4;
    localparam int HT = 3;
    localparam int GT = 1;
    localparam int BT = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  req = 3'b000;
    logic [2:0]  blink = 3'b000;
    logic [15:0] msg0 = 16'h0000;
    logic [15:0] msg1 = 16'h0000;
    logic [15:0] msg2 = 16'h0000;
    logic [2:0]  grant;
    logic        done;
    logic [15:0] graphics;

    int checks = 0;
    int failures = 0;

    logic [19:0] expq[$];

    // Reference model: state as plain integers, elapsed cycles in the current phase
    int m_state = 0;
    int m_owner = 0;
    int m_last = 2;
    int m_elapsed = 0;
    bit m_blink = 1'b0;

    always #5 clk = ~clk;

    display_scheduler #(
        .TICK_DIV(TD), .HOLD_TICKS(HT), .GAP_TICKS(GT), .BLINK_TICKS(BT)
    ) dut (
        .clk(clk), .reset(reset), .req(req),
        .msg0(msg0), .msg1(msg1), .msg2(msg2),
        .blink(blink), .grant(grant), .done(done), .graphics(graphics)
    );

    task automatic step(input bit rst, input logic [2:0] r, input logic [2:0] b,
                        input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        logic [47:0] all;
        logic [47:0] sh;
        logic [2:0]  rs;
        logic [2:0]  g;
        logic        d;
        logic [15:0] gfx;
        bit          vis;
        bit          found;
        @(negedge clk);
        reset = rst; req = r; blink = b; msg0 = a0; msg1 = a1; msg2 = a2;
        all = {a2, a1, a0};
        g = 3'b000; d = 1'b0; gfx = 16'hFFFF;
        if (rst) begin
            m_state = 0; m_last = 2; m_elapsed = 0;
        end else begin
            case (m_state)
                0: begin
                    found = 1'b0;
                    for (int i = 0; i < 3; i++) begin
                        int c;
                        c = (m_last + 1 + i) % 3;
                        rs = r >> c;
                        if (!found && rs[0]) begin
                            found = 1'b1;
                            m_owner = c;
                        end
                    end
                    if (found) begin
                        m_last = m_owner;
                        rs = b >> m_owner;
                        m_blink = rs[0];
                        m_state = 1;
                        m_elapsed = 0;
                        g = 3'b001 << m_owner;
                        sh = all >> (16 * m_owner);
                        gfx = sh[15:0];
                    end
                end
                1: begin
                    rs = r >> m_owner;
                    if (!rs[0]) begin
                        m_state = 2; m_elapsed = 0;
                    end else if (m_elapsed + 1 == HT * TD) begin
                        m_state = 2; m_elapsed = 0; d = 1'b1;
                    end else begin
                        m_elapsed++;
                        vis = !m_blink || ((m_elapsed / (BT * TD)) % 2 == 0);
                        g = 3'b001 << m_owner;
                        sh = all >> (16 * m_owner);
                        gfx = vis ? sh[15:0] : 16'hFFFF;
                    end
                end
                default: begin
                    if (m_elapsed + 1 == GT * TD) begin
                        m_state = 0; m_elapsed = 0;
                    end else begin
                        m_elapsed++;
                    end
                end
            endcase
        end
        expq.push_back({g, d, gfx});
    endtask

    task automatic hold_req(input int n, input logic [2:0] r, input logic [2:0] b,
                            input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2);
        for (int k = 0; k < n; k++) step(1'b0, r, b, a0, a1, a2);
    endtask

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp_v);
        end
    endtask

    // Monitor: every cycle after an expectation was queued, compare the registered outputs.
    initial begin
        logic [19:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                compare("grant", {13'd0, grant}, {13'd0, e[19:17]});
                compare("done", {15'd0, done}, {15'd0, e[16]});
                compare("graphics", graphics, e[15:0]);
            end
        end
    end

    initial begin
        logic [2:0]  r;
        logic [2:0]  b;
        logic [15:0] a0;
        logic [15:0] a1;
        logic [15:0] a2;
        int          len;

        step(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        step(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        // basic hold and regrant
        hold_req(40, 3'b001, 3'b000, 16'h1234, 16'h5678, 16'h9ABC);
        step(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        // round-robin across all three
        hold_req(70, 3'b111, 3'b000, 16'h1111, 16'h2222, 16'h3333);
        step(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        // blinking owner
        hold_req(20, 3'b010, 3'b010, 16'h0000, 16'hABCD, 16'h0000);
        step(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        // abort by dropping the owner's request
        hold_req(6, 3'b100, 3'b000, 16'h0, 16'h0, 16'h4321);
        hold_req(8, 3'b000, 3'b000, 16'h0, 16'h0, 16'h4321);
        // reset during SHOW, then during GAP, then requester 1 wins first
        hold_req(5, 3'b001, 3'b000, 16'h7777, 16'h0, 16'h0);
        step(1'b1, 3'b001, 3'b000, 16'h7777, 16'h0, 16'h0);
        hold_req(15, 3'b001, 3'b000, 16'h7777, 16'h0, 16'h0);
        step(1'b1, 3'b001, 3'b000, 16'h7777, 16'h0, 16'h0);
        hold_req(10, 3'b110, 3'b000, 16'h0, 16'h6666, 16'h5555);
        step(1'b1, 3'b000, 3'b000, 16'h0, 16'h0, 16'h0);
        // request raised only in GAP must wait for IDLE
        hold_req(14, 3'b001, 3'b000, 16'h1010, 16'h2020, 16'h0);
        hold_req(20, 3'b010, 3'b000, 16'h1010, 16'h2020, 16'h0);

        // randomized segments with mid-show message changes and rare resets
        a0 = 16'h0123; a1 = 16'h4567; a2 = 16'h89AB;
        for (int seg = 0; seg < 150; seg++) begin
            r = 3'($urandom_range(0, 7));
            b = 3'($urandom_range(0, 7));
            len = $urandom_range(1, 40);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 9) == 0) a0 = 16'($urandom);
                if ($urandom_range(0, 9) == 0) a1 = 16'($urandom);
                if ($urandom_range(0, 9) == 0) a2 = 16'($urandom);
                step($urandom_range(0, 299) == 0, r, b, a0, a1, a2);
            end
        end

        repeat (3) @(posedge clk);
        #3;
        checks++;
        if (expq.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, expected 0", expq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
